// File: rtl/vec_mem_ctrl.sv
// vec_mem_ctrl: serializes scalar/vector load-store requests onto a single-port word RAM
module vec_mem_ctrl #(
    parameter int ADDR_W = 13,
    parameter int LANES  = 16,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      mem_write,
    input  logic                      vec_scalar,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANES*DATA_W-1:0]   wdata,
    output logic [LANES*DATA_W-1:0]   rdata,
    output logic                      rdata_valid,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_rdata
);
    localparam int LW = $clog2(LANES);
    localparam int CW = LW + 1;
    typedef enum logic [2:0] {IDLE, WR, RD, RD_LAST, RESP} ctrlState;
    ctrlState state, nextState;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] base, beatAddr, holdAddr;
    logic [DATA_W-1:0] holdWdata;
    logic isVec, accept, lastBeat, capture, beating;
    logic [LW-1:0] wrLane, rdLane;
    logic [LANES-1:0][DATA_W-1:0] wbuf, rbuf, rbufMerge;
    // beat bookkeeping: acceptance, last beat, lane selection and read-word merge
    always_comb begin
        accept = req_valid && (state == IDLE || state == RESP);
        beating = state == WR || state == RD;
        lastBeat = cnt == (isVec ? CW'(LANES - 1) : CW'(0));
        beatAddr = base + ADDR_W'(cnt);
        wrLane = LW'(LANES - 1 - int'(cnt));
        rdLane = LW'(LANES - int'(cnt));
        capture = (state == RD && cnt != '0) || state == RD_LAST;
        rbufMerge = rbuf;
        rbufMerge[rdLane] = ram_rdata;
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nextState;
    end
    // next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE, RESP: nextState = accept ? (mem_write ? WR : RD) : IDLE;
            WR:         nextState = lastBeat ? IDLE : WR;
            RD:         nextState = lastBeat ? RD_LAST : RD;
            RD_LAST:    nextState = RESP;
            default:    nextState = IDLE;
        endcase
    end
    // outputs: RAM port follows the active beat, otherwise holds its last value
    always_comb begin
        ram_we = state == WR;
        ram_addr = beating ? beatAddr : holdAddr;
        ram_wdata = state == WR ? wbuf[wrLane] : holdWdata;
        busy = beating || state == RD_LAST;
        rdata_valid = state == RESP;
    end
    // request capture, beat counter, read assembly and response register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            isVec <= 1'b0;
            cnt <= '0;
            wbuf <= '0;
            rbuf <= '0;
            holdAddr <= '0;
            holdWdata <= '0;
            rdata <= '0;
        end else begin
            if (accept) begin
                base <= addr;
                isVec <= vec_scalar;
                wbuf <= wdata;
                rbuf <= '0;
                cnt <= '0;
            end else if (beating) cnt <= cnt + 1'b1;
            if (beating) begin
                holdAddr <= ram_addr;
                holdWdata <= ram_wdata;
            end
            if (capture) rbuf <= rbufMerge;
            if (state == RD_LAST) rdata <= rbufMerge;
        end
    end
endmodule

// File: tb/tb_vec_mem_ctrl.sv
// tb_vec_mem_ctrl: scoreboard bench for vec_mem_ctrl with a registered RAM model
module tb_vec_mem_ctrl;
    logic clk = 0, rst = 0, req_valid = 0, mem_write = 0, vec_scalar = 0;
    logic [12:0] addr = '0;
    logic [511:0] wdata = '0, rdata;
    logic rdata_valid, busy, ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata = '0;
    logic [31:0] mem [0:8191];
    int cyc = 0, nCmp = 0, nBad = 0;
    typedef struct {logic [12:0] a; logic [31:0] d;} wrExp;
    typedef struct {logic [511:0] d; int due;} rdExp;
    wrExp wq[$];
    rdExp rq[$];
    wrExp w;
    rdExp r;
    logic [511:0] wd, er;
    int b;

    vec_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
        .vec_scalar(vec_scalar), .addr(addr), .wdata(wdata), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we) begin
            chk("wrExpected", 512'(wq.size() != 0), 512'd1);
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("wrAddr", 512'(ram_addr), 512'(w.a));
                chk("wrData", 512'(ram_wdata), 512'(w.d));
            end
        end
        if (rdata_valid) begin
            chk("rdExpected", 512'(rq.size() != 0), 512'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("rdData", rdata, r.d);
                chk("rdLatency", 512'(cyc), 512'(r.due));
            end
        end
    end

    task automatic issue(input logic we, input logic vec, input logic [12:0] a,
                         input logic [511:0] d, input int nWr, input logic [511:0] expR);
        int n;
        n = vec ? 16 : 1;
        req_valid = 1; mem_write = we; vec_scalar = vec; addr = a; wdata = d;
        @(posedge clk); #1;
        req_valid = 0;
        if (we) for (int k = 0; k < nWr; k++) wq.push_back('{a + 13'(k), d[(15 - k) * 32 +: 32]});
        else rq.push_back('{expR, cyc + n + 1});
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || rdata_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idleTimeout", 512'(busy), 512'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstRdata", rdata, '0);
        chk("rstValid", 512'(rdata_valid), '0);
        chk("rstBusy", 512'(busy), '0);
        chk("rstWe", 512'(ram_we), '0);
        chk("rstAddr", 512'(ram_addr), '0);
        chk("rstWdata", 512'(ram_wdata), '0);
        rst = 1;
        @(posedge clk); #1;

        wd = '0; wd[15*32 +: 32] = 32'hDEADBEEF;
        issue(1, 0, 13'h0040, wd, 1, '0);
        chk("scalarBusy", 512'(busy), 512'd1);
        @(posedge clk); #1;
        chk("scalarBusyLen", 512'(busy), 512'd0);
        waitIdle();

        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'h1000 + i;
        issue(1, 1, 13'h0100, wd, 16, '0);
        b = 0;
        while (busy && b < 40) begin
            b++;
            @(posedge clk); #1;
        end
        chk("vecBusyLen", 512'(b), 512'd16);
        waitIdle();

        for (int i = 0; i < 16; i++) er[i*32 +: 32] = 32'h1000 + i;
        issue(0, 1, 13'h0100, '0, 0, er);
        waitIdle();

        wd = '0; wd[15*32 +: 32] = 32'hA5A5A5A5;
        issue(1, 0, 13'h1FFF, wd, 1, '0);
        waitIdle();
        wd = '0; wd[15*32 +: 32] = 32'h7;
        issue(1, 0, 13'h0000, wd, 1, '0);
        waitIdle();
        er = '0; er[15*32 +: 32] = 32'hA5A5A5A5; er[14*32 +: 32] = 32'h7;
        issue(0, 1, 13'h1FFF, '0, 0, er);
        waitIdle();
        er = '0; er[15*32 +: 32] = 32'hA5A5A5A5;
        issue(0, 0, 13'h1FFF, '0, 0, er);
        waitIdle();

        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'h2000 + i;
        issue(1, 1, 13'h0200, wd, 16, '0);
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1; mem_write = 1; vec_scalar = 0; addr = 13'h0300; wdata = '1;
        @(posedge clk); #1;
        req_valid = 0;
        waitIdle();
        chk("droppedReq", 512'(mem[13'h0300]), '0);

        er = '0; er[15*32 +: 32] = 32'hA5A5A5A5;
        issue(0, 0, 13'h1FFF, '0, 0, er);
        b = 0;
        while (!rdata_valid && b < 10) begin
            @(posedge clk); #1;
            b++;
        end
        chk("respSeen", 512'(rdata_valid), 512'd1);
        er = '0; er[15*32 +: 32] = 32'hDEADBEEF;
        issue(0, 0, 13'h0040, '0, 0, er);
        chk("respAccept", 512'(busy), 512'd1);
        waitIdle();

        for (int i = 0; i < 16; i++) wd[i*32 +: 32] = 32'h4000 + i;
        issue(1, 1, 13'h0400, wd, 7, '0);
        repeat (7) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("abortWe", 512'(ram_we), '0);
        chk("abortBusy", 512'(busy), '0);
        chk("abortRdata", rdata, '0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("postRstBusy", 512'(busy), '0);
        chk("beat6Written", 512'(mem[13'h0406]), 512'h4009);
        chk("beat7Dropped", 512'(mem[13'h0407]), '0);
        er = '0; er[15*32 +: 32] = 32'h400F;
        issue(0, 0, 13'h0400, '0, 0, er);
        waitIdle();

        b = 0;
        while ((rq.size() != 0 || wq.size() != 0) && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        chk("rdQueueEmpty", 512'(rq.size()), '0);
        chk("wrQueueEmpty", 512'(wq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/vec_mem_ctrl.md
Name: vec_mem_ctrl

Overview:
- Data-memory sequencer that sits directly downstream of the vector CPU's memory port.
- Accepts scalar or 16-lane vector load/store requests (address, 16x32 write data, write enable, vector/scalar flag) and serializes them onto a single-port, 32-bit-wide word RAM.
- Returns assembled 16x32 read data to the CPU's read-data input.
- Signals busy while a multi-beat transfer is in flight.

Parameters:
- ADDR_W, 13, word-address width (matches CPU addr bus)
- LANES, 16, vector lanes per request
- DATA_W, 32, bits per lane / RAM word

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request strobe from CPU memory stage
- mem_write  in  1  1 = store, 0 = load
- vec_scalar  in  1  1 = vector (LANES beats), 0 = scalar (1 beat, lane LANES-1)
- addr  in  ADDR_W  base word address
- wdata  in  LANES x DATA_W  store data, lane LANES-1 is the scalar lane
- rdata  out  LANES x DATA_W  assembled load data to CPU
- rdata_valid  out  1  one-cycle pulse: rdata updated
- busy  out  1  controller not accepting requests
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write word
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read word, valid 1 cycle after ram_addr (registered RAM)

Behaviour:
- Reset (rst=0, async): state=IDLE, beat counter=0. rdata=0, rdata_valid=0, busy=0, ram_we=0, ram_addr=0, ram_wdata=0. Reset mid-transfer aborts it; no further RAM writes and no rdata_valid.
- States: IDLE, WR, RD, RD_LAST, RESP.
- Accept: in IDLE or RESP with req_valid=1, capture addr, wdata, mem_write and vec_scalar on the clock edge. Set N = LANES if vec_scalar else 1. Set cnt=0. Next state is WR (store) or RD (load).
- Requests with req_valid=1 while busy=1 are ignored (dropped, not queued). The requester must re-present them.
- Lane/address mapping: beat k (0..N-1) addresses base+k, modulo 2^ADDR_W (wraps 8191->0). Beat k corresponds to lane LANES-1-k. Scalar therefore uses lane LANES-1 at base.
- WR: each cycle drive ram_we=1, ram_addr=base+cnt, ram_wdata=wbuf[LANES-1-cnt], then cnt++. After beat N-1, go to IDLE. busy=1 throughout WR.
  - Scalar store: 1 WR cycle.
  - Vector store: 16 WR cycles.
- RD: each cycle drive ram_we=0, ram_addr=base+cnt, then cnt++. Each cycle after the first, capture ram_rdata into rbuf[LANES-1-(cnt-1)]. After issuing beat N-1, go to RD_LAST.
- RD_LAST: capture the final word. rbuf lanes not read are zero; for scalar, lanes LANES-2..0 = 0. busy=1 in RD and RD_LAST.
- RESP: rdata<=rbuf (registered, visible this cycle), rdata_valid=1 for exactly one cycle, busy=0. A new request may be accepted in RESP. With no request, go to IDLE.
- Load latency from accept edge to rdata_valid:
  - scalar: 3 cycles (RD, RD_LAST, RESP)
  - vector: LANES+2 = 18 cycles
- rdata holds its value until the next RESP; it is never cleared except by reset.
- Outside WR, ram_we=0. ram_addr/ram_wdata hold their last value when idle.
- The beat counter is log2(LANES)+1 bits wide, with no overflow for N=LANES.

Test Plan:
- Scalar store: addr=0x0040, wdata[15]=0xDEADBEEF, vec_scalar=0 -> one cycle with ram_we=1, ram_addr=0x0040, ram_wdata=0xDEADBEEF. busy high 1 cycle.
- Vector store: addr=0x0100, wdata[i]=0x1000+i -> 16 consecutive writes, ram_addr 0x0100..0x010F carrying 0x100F down to 0x1000. busy high exactly 16 cycles.
- Vector load after that store: addr=0x0100 -> rdata_valid pulses 18 cycles after accept. rdata[i]=0x1000+i for all i.
- Scalar load with wrap: RAM[0x1FFF]=0xA5A5A5A5, RAM[0]=7, vector load addr=0x1FFF -> rdata[15]=0xA5A5A5A5, rdata[14]=7. A scalar load at 0x1FFF gives rdata[15]=0xA5A5A5A5 and rdata[14:0]=0.
- Request while busy: issue a vector store, then assert a second req_valid at cycle 5 -> second request ignored (no extra writes). A request presented in the RESP cycle is accepted.
- Reset mid-transfer: drop rst at beat 7 of a vector store -> ram_we=0 immediately, busy=0, rdata=0. After release, no residual writes and the controller is ready next cycle.
